// File: rtl/formula_arg_scheduler_pkg.sv
// Shared types and defaults for the formula argument scheduler.
// The triple layout is the one the formula tops consume.
package formula_sched_pkg;

   localparam int arg_width_def = 32;
   localparam int timeout_def   = 256;

   typedef struct packed {
      logic [arg_width_def-1:0] a;
      logic [arg_width_def-1:0] b;
      logic [arg_width_def-1:0] c;
   } arg_triple_t;

endpackage

// File: rtl/formula_arg_scheduler_if.sv
// Handshake and status bundle between the upstream source, the scheduler and the formula top.
// The slave modport is the scheduler's view; master is the driving environment.
interface formula_arg_scheduler_if #(
   parameter int arg_width = formula_sched_pkg::arg_width_def,
   parameter int cnt_w     = 1
) ();

   logic                 in_vld;
   logic                 in_rdy;
   logic [arg_width-1:0] in_a;
   logic [arg_width-1:0] in_b;
   logic [arg_width-1:0] in_c;
   logic                 arg_vld;
   logic [arg_width-1:0] a;
   logic [arg_width-1:0] b;
   logic [arg_width-1:0] c;
   logic                 res_vld;
   logic [cnt_w-1:0]     n_outstanding;
   logic                 busy;
   logic                 err_unexpected;
   logic                 err_timeout;

   modport slave (
      input  in_vld, in_a, in_b, in_c, res_vld,
      output in_rdy, arg_vld, a, b, c, n_outstanding, busy, err_unexpected, err_timeout
   );

   modport master (
      output in_vld, in_a, in_b, in_c, res_vld,
      input  in_rdy, arg_vld, a, b, c, n_outstanding, busy, err_unexpected, err_timeout
   );

endinterface

// File: rtl/formula_arg_fifo.sv
// Flip-flop FIFO for argument triples; pointers carry an extra wrap bit
// so that full and empty are told apart without a separate count.
module formula_arg_fifo
   import formula_sched_pkg::*;
#(
   parameter type elem_t = arg_triple_t,
   parameter int  depth  = 4
) (
   input  logic  clk,
   input  logic  rst,
   input  logic  push,
   input  logic  pop,
   input  elem_t wr_data,
   output elem_t rd_data,
   output logic  full,
   output logic  empty
);

   localparam int idx_w = $clog2(depth);
   localparam int ptr_w = idx_w + 1;

   logic [ptr_w-1:0] wr_ptr;
   logic [ptr_w-1:0] rd_ptr;
   elem_t            mem [depth];
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[idx_w-1:0] == rd_ptr[idx_w-1:0]) &&
                    (wr_ptr[idx_w] != rd_ptr[idx_w]);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rd_data = mem[rd_ptr[idx_w-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + ptr_w'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + ptr_w'(1);
      end
   end

   // Storage is not reset: an entry is only ever read after it was written.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[idx_w-1:0]] <= wr_data;
   end

endmodule

// File: rtl/formula_arg_scheduler.sv
// Buffers argument triples and issues them to a formula top under a credit limit,
// flagging results that arrive unasked and requests that never get answered.
module formula_arg_scheduler
   import formula_sched_pkg::*;
#(
   parameter int arg_width  = arg_width_def,
   parameter int depth      = 4,
   parameter int n_inflight = 1,
   parameter int timeout    = timeout_def
) (
   input logic                    clk,
   input logic                    rst,
   formula_arg_scheduler_if.slave bus
);

   localparam int               cnt_w   = $clog2(n_inflight + 1);
   localparam logic [cnt_w-1:0] max_out = cnt_w'(n_inflight);
   localparam int               wd_w    = $clog2(timeout + 1);
   localparam logic [wd_w-1:0]  wd_max  = wd_w'(timeout);
   localparam logic [wd_w-1:0]  wd_last = wd_w'(timeout - 1);

   typedef struct packed {
      logic [arg_width-1:0] a;
      logic [arg_width-1:0] b;
      logic [arg_width-1:0] c;
   } triple_t;

   triple_t              wr_data;
   triple_t              head;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic                 res;
   logic                 arg_vld_q;
   logic [arg_width-1:0] a_q;
   logic [arg_width-1:0] b_q;
   logic [arg_width-1:0] c_q;
   logic [cnt_w-1:0]     n_out;
   logic [cnt_w-1:0]     n_out_nxt;
   logic [wd_w-1:0]      wd;
   logic                 err_unexp_q;
   logic                 err_to_q;

   assign wr_data = '{a: bus.in_a, b: bus.in_b, c: bus.in_c};
   assign res     = bus.res_vld;
   assign push    = bus.in_vld & ~full;
   assign pop     = ~empty & (n_out < max_out);

   formula_arg_fifo #(
      .elem_t (triple_t),
      .depth  (depth)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (push),
      .pop     (pop),
      .wr_data (wr_data),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arg_vld_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
      end else begin
         arg_vld_q <= pop;
         if (pop) begin
            a_q <= head.a;
            b_q <= head.b;
            c_q <= head.c;
         end
      end
   end

   // A result with nothing outstanding is flagged, not counted, so the count never wraps.
   always_comb begin
      n_out_nxt = n_out;
      if (pop && !res)
         n_out_nxt = n_out + cnt_w'(1);
      else if (!pop && res && (n_out != '0))
         n_out_nxt = n_out - cnt_w'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_out       <= '0;
         err_unexp_q <= 1'b0;
      end else begin
         n_out <= n_out_nxt;
         if (res && !pop && (n_out == '0)) err_unexp_q <= 1'b1;
      end
   end

   // Watchdog measures the gap since the last result while anything is in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd       <= '0;
         err_to_q <= 1'b0;
      end else if (res || (n_out == '0)) begin
         wd <= '0;
      end else if (wd != wd_max) begin
         wd <= wd + wd_w'(1);
         if (wd == wd_last) err_to_q <= 1'b1;
      end
   end

   assign bus.in_rdy         = ~full;
   assign bus.arg_vld        = arg_vld_q;
   assign bus.a              = a_q;
   assign bus.b              = b_q;
   assign bus.c              = c_q;
   assign bus.n_outstanding  = n_out;
   assign bus.busy           = ~empty | (n_out != '0);
   assign bus.err_unexpected = err_unexp_q;
   assign bus.err_timeout    = err_to_q;

endmodule

// File: tb/tb_formula_arg_scheduler.sv
// Directed bench for formula_arg_scheduler: one instance with a single credit and a
// short watchdog, a second with two credits for the simultaneous issue/result case.
module tb_formula_arg_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   formula_arg_scheduler_if #(.arg_width(32), .cnt_w(1)) bus1 ();
   formula_arg_scheduler_if #(.arg_width(32), .cnt_w(2)) bus2 ();

   formula_arg_scheduler #(.arg_width(32), .depth(4), .n_inflight(1), .timeout(16)) dut1 (
      .clk (clk), .rst (rst), .bus (bus1)
   );

   formula_arg_scheduler #(.arg_width(32), .depth(4), .n_inflight(2), .timeout(16)) dut2 (
      .clk (clk), .rst (rst), .bus (bus2)
   );

   int          n_checks = 0;
   int          n_err    = 0;
   logic        man_res  = 1'b0;
   logic        rsp_res  = 1'b0;
   logic        resp_en  = 1'b0;
   logic [95:0] issued_q [$];
   int          tb_cnt   = 0;
   int          max_cnt  = 0;

   assign bus1.res_vld = man_res | rsp_res;

   task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offer a triple to dut1 and return just after the edge that accepts it.
   task automatic push1(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc);
      int n;
      n = 0;
      bus1.in_vld = 1'b1;
      bus1.in_a   = va;
      bus1.in_b   = vb;
      bus1.in_c   = vc;
      while (!bus1.in_rdy && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) chk("push_rdy_wait", 0, 1);
      tick();
      bus1.in_vld = 1'b0;
   endtask

   task automatic chk_reset1(input string tag);
      chk({tag, "_in_rdy"}, bus1.in_rdy, 1);
      chk({tag, "_arg_vld"}, bus1.arg_vld, 0);
      chk({tag, "_abc"}, {bus1.a, bus1.b, bus1.c}, 0);
      chk({tag, "_n_out"}, bus1.n_outstanding, 0);
      chk({tag, "_busy"}, bus1.busy, 0);
      chk({tag, "_err_unexp"}, bus1.err_unexpected, 0);
      chk({tag, "_err_to"}, bus1.err_timeout, 0);
   endtask

   // Responder for dut1: answers each issue 5 cycles after its arg_vld pulse.
   always begin
      @(posedge clk);
      #2;
      if (resp_en && bus1.arg_vld) begin
         issued_q.push_back({bus1.a, bus1.b, bus1.c});
         repeat (4) @(posedge clk);
         #1 rsp_res = 1'b1;
         @(posedge clk);
         #1 rsp_res = 1'b0;
      end
   end

   // Independent in-flight tally for dut1 from the observed pulses.
   always @(posedge clk) begin
      #3;
      if (rst) begin
         tb_cnt = 0;
      end else begin
         if (bus1.arg_vld) tb_cnt++;
         if (bus1.res_vld && tb_cnt > 0) tb_cnt--;
         if (tb_cnt > max_cnt) max_cnt = tb_cnt;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int n;
      bus1.in_vld = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_c = '0;
      bus2.in_vld = 1'b0; bus2.in_a = '0; bus2.in_b = '0; bus2.in_c = '0;
      bus2.res_vld = 1'b0;

      // reset state
      repeat (3) tick();
      chk_reset1("rst");
      chk("rst_n_out2", bus2.n_outstanding, 0);
      rst = 1'b0;
      tick();

      // single triple, 2-cycle latency
      push1(32'd1, 32'd4, 32'd9);
      chk("t1_arg_vld_early", bus1.arg_vld, 0);
      tick();
      chk("t1_arg_vld", bus1.arg_vld, 1);
      chk("t1_abc", {bus1.a, bus1.b, bus1.c}, {32'd1, 32'd4, 32'd9});
      chk("t1_n_out", bus1.n_outstanding, 1);
      chk("t1_busy", bus1.busy, 1);
      man_res = 1'b1;
      tick();
      man_res = 1'b0;
      chk("t1_arg_vld_pulse", bus1.arg_vld, 0);
      chk("t1_n_out_ret", bus1.n_outstanding, 0);
      chk("t1_busy_fall", bus1.busy, 0);
      chk("t1_abc_hold", {bus1.a, bus1.b, bus1.c}, {32'd1, 32'd4, 32'd9});

      // burst of six with latency-5 responder
      issued_q.delete();
      max_cnt = 0;
      resp_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 4) chk("t2_rdy_before_full", bus1.in_rdy, 1);
         if (i == 5) chk("t2_rdy_full", bus1.in_rdy, 0);
         push1(i, i, i);
      end
      n = 0;
      while ((issued_q.size() < 6 || bus1.busy) && n < 300) begin
         tick();
         n++;
      end
      chk("t2_drain_wait", (n < 300), 1);
      resp_en = 1'b0;
      chk("t2_count", issued_q.size(), 6);
      for (int k = 0; k < 6; k++)
         chk($sformatf("t2_order%0d", k), issued_q[k], {3{k[31:0]}});
      chk("t2_max_inflight", max_cnt, 1);

      // full FIFO with a waiting upstream
      issued_q.delete();
      for (int i = 10; i < 15; i++) push1(i, i, i);
      bus1.in_vld = 1'b1;
      bus1.in_a = 32'd7; bus1.in_b = 32'd7; bus1.in_c = 32'd7;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("t3_rdy_low%0d", k), bus1.in_rdy, 0);
         tick();
      end
      man_res = 1'b1;
      resp_en = 1'b1;
      tick();
      man_res = 1'b0;
      chk("t3_rdy_still_low", bus1.in_rdy, 0);
      chk("t3_n_out_zero", bus1.n_outstanding, 0);
      tick();
      chk("t3_rdy_after_pop", bus1.in_rdy, 1);
      tick();
      bus1.in_vld = 1'b0;
      n = 0;
      while ((issued_q.size() < 5 || bus1.busy) && n < 300) begin
         tick();
         n++;
      end
      chk("t3_drain_wait", (n < 300), 1);
      resp_en = 1'b0;
      chk("t3_count", issued_q.size(), 5);
      chk("t3_q0", issued_q[0], {3{32'd11}});
      chk("t3_q1", issued_q[1], {3{32'd12}});
      chk("t3_q2", issued_q[2], {3{32'd13}});
      chk("t3_q3", issued_q[3], {3{32'd14}});
      chk("t3_q4", issued_q[4], {3{32'd7}});
      chk("t3_no_timeout", bus1.err_timeout, 0);
      chk("t3_no_unexp", bus1.err_unexpected, 0);

      // n_inflight=2: issue and result in the same cycle
      bus2.in_vld = 1'b1;
      bus2.in_a = 32'h21; bus2.in_b = 32'h21; bus2.in_c = 32'h21;
      tick();
      chk("t4_n_out_pre", bus2.n_outstanding, 0);
      bus2.in_a = 32'h22; bus2.in_b = 32'h22; bus2.in_c = 32'h22;
      tick();
      bus2.in_vld = 1'b0;
      chk("t4_first_vld", bus2.arg_vld, 1);
      chk("t4_first_a", bus2.a, 32'h21);
      chk("t4_n_out_1", bus2.n_outstanding, 1);
      bus2.res_vld = 1'b1;
      tick();
      bus2.res_vld = 1'b0;
      chk("t4_second_vld", bus2.arg_vld, 1);
      chk("t4_second_a", bus2.a, 32'h22);
      chk("t4_n_out_same", bus2.n_outstanding, 1);
      bus2.res_vld = 1'b1;
      tick();
      bus2.res_vld = 1'b0;
      chk("t4_n_out_end", bus2.n_outstanding, 0);
      chk("t4_busy_end", bus2.busy, 0);
      chk("t4_no_unexp", bus2.err_unexpected, 0);

      // watchdog with timeout=16
      push1(32'd5, 32'd5, 32'd5);
      n = 0;
      while (!bus1.arg_vld && n < 10) begin
         tick();
         n++;
      end
      chk("t6_issue", bus1.arg_vld, 1);
      repeat (15) tick();
      chk("t6_err_to_early", bus1.err_timeout, 0);
      tick();
      chk("t6_err_to", bus1.err_timeout, 1);
      chk("t6_n_out", bus1.n_outstanding, 1);
      push1(32'd6, 32'd6, 32'd6);
      chk("t6_busy", bus1.busy, 1);
      chk("t6_err_to_hold", bus1.err_timeout, 1);

      // reset in the middle of operation
      #2 rst = 1'b1;
      #1;
      chk_reset1("t6_midrst");
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk("t6_post_rst_vld", bus1.arg_vld, 0);
      chk("t6_post_rst_busy", bus1.busy, 0);

      // stale result after reset
      man_res = 1'b1;
      tick();
      man_res = 1'b0;
      chk("t5_err_unexp", bus1.err_unexpected, 1);
      chk("t5_n_out", bus1.n_outstanding, 0);
      repeat (3) tick();
      chk("t5_err_unexp_hold", bus1.err_unexpected, 1);
      chk("t5_n_out_hold", bus1.n_outstanding, 0);
      chk("t5_err_to_clear", bus1.err_timeout, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
